// File: rtl/fetch_if.sv
// fetch_if: bundle of the fetch stage's control, memory and IF/ID signals.
//   master modport: the surrounding pipeline / memory model (drives start,
//                   stall, branch redirect and memory read data).
//   slave modport : the fetch stage (drives memory address and IF/ID outputs).
interface fetch_if #(
   parameter int ADDR_W  = 18,
   parameter int INSTR_W = 18
);
   logic               start;
   logic               stall;
   logic               branch_taken;
   logic [ADDR_W-1:0]  branch_target;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rd;
   logic [INSTR_W-1:0] instr_out;
   logic [ADDR_W-1:0]  pc_out;
   logic               valid_out;
   logic               halted;
   logic               fetch_err;

   modport master (
      output start, stall, branch_taken, branch_target, imem_rd,
      input  imem_addr, instr_out, pc_out, valid_out, halted, fetch_err
   );

   modport slave (
      input  start, stall, branch_taken, branch_target, imem_rd,
      output imem_addr, instr_out, pc_out, valid_out, halted, fetch_err
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 18-bit vector processor.
//   Owns the PC, presents it as a byte address to instruction memory, and
//   registers the returned word into the IF/ID register.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_if.slave: start/stall/branch inputs, imem address/data,
//          IF/ID outputs (instr_out, pc_out, valid_out), halted, fetch_err
// Control: IDLE -> (start) -> RUN -> (FINISH word or out-of-range PC) -> HALT
//          HALT -> (start) -> RUN.
module fetch_stage #(
   parameter int                 ADDR_W      = 18,
   parameter int                 INSTR_W     = 18,
   parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
   parameter int                 MEM_WORDS   = 101,
   parameter logic [INSTR_W-1:0] FINISH_WORD = 18'b011000000000000000
) (
   input  logic    clk,
   input  logic    rst,
   fetch_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(MEM_WORDS);

   state_t             state_reg,  state_next;
   logic [ADDR_W-1:0]  pc_reg,     pc_next;
   logic [INSTR_W-1:0] instr_reg,  instr_next;
   logic [ADDR_W-1:0]  pcout_reg,  pcout_next;
   logic               valid_reg,  valid_next;
   logic               ferr_reg,   ferr_next;

   logic               out_of_range;

   // Word index of the PC compared against the number of valid words.
   assign out_of_range = {2'b00, pc_reg[ADDR_W-1:2]} >= WORD_LIMIT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
         instr_reg <= '0;
         pcout_reg <= '0;
         valid_reg <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         instr_reg <= instr_next;
         pcout_reg <= pcout_next;
         valid_reg <= valid_next;
         ferr_reg  <= ferr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      instr_next = instr_reg;
      pcout_next = pcout_reg;
      valid_next = valid_reg;
      ferr_next  = ferr_reg;

      case (state_reg)
         IDLE: begin
            valid_next = 1'b0;
            if (bus.start) begin
               state_next = RUN;
               pc_next    = RESET_PC;
            end
         end

         RUN: begin
            if (bus.branch_taken) begin
               // Redirect wins over stall; the slot fetched this cycle is
               // on the wrong path, so it is dropped.
               pc_next    = {bus.branch_target[ADDR_W-1:2], 2'b00};
               valid_next = 1'b0;
            end else if (bus.stall) begin
               // everything held
            end else if (out_of_range) begin
               valid_next = 1'b0;
               ferr_next  = 1'b1;
               state_next = HALT;
            end else if (bus.imem_rd == FINISH_WORD) begin
               // FINISH is delivered to decode, PC stays parked on it.
               instr_next = bus.imem_rd;
               pcout_next = pc_reg;
               valid_next = 1'b1;
               state_next = HALT;
            end else begin
               instr_next = bus.imem_rd;
               pcout_next = pc_reg;
               valid_next = 1'b1;
               pc_next    = pc_reg + ADDR_W'(4);
            end
         end

         HALT: begin
            if (bus.start) begin
               state_next = RUN;
               pc_next    = RESET_PC;
               ferr_next  = 1'b0;
               valid_next = 1'b0;
            end else if (!bus.stall) begin
               // Retire the FINISH word after it has been seen once.
               valid_next = 1'b0;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign bus.imem_addr = pc_reg;
   assign bus.instr_out = instr_reg;
   assign bus.pc_out    = pcout_reg;
   assign bus.valid_out = valid_reg;
   assign bus.halted    = (state_reg == HALT);
   assign bus.fetch_err = ferr_reg;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table of per-cycle vectors plus hand-written
// sequences for out-of-range halt and asynchronous reset.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_if #(.ADDR_W(18), .INSTR_W(18)) bus ();

   fetch_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [17:0] mem [0:127];
   assign bus.imem_rd = mem[bus.imem_addr[8:2]];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        start;
      logic        stall;
      logic        br;
      logic [17:0] tgt;
      logic        chk_data;
      logic        valid;
      logic [17:0] pc;
      logic [17:0] instr;
      logic [17:0] addr;
      logic        halted;
      logic        ferr;
   } vec_t;

   vec_t vecs [20];

   initial begin
      int          cnt;
      logic [17:0] last_pc;
      logic [17:0] last_instr;
      bit          done;

      for (int i = 0; i < 128; i++) mem[i] = 18'h00100 + 18'(i);
      mem[29] = 18'h18000;

      //          start stall br tgt      chk valid pc        instr     addr     halt ferr
      vecs[0]  = '{1'b1,1'b0,1'b0,18'h00, 1'b1,1'b0,18'h00, 18'h00000,18'h00, 1'b0,1'b0};
      vecs[1]  = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h00, 18'h00100,18'h04, 1'b0,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h04, 18'h00101,18'h08, 1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b1,1'b0,18'h00, 1'b1,1'b1,18'h04, 18'h00101,18'h08, 1'b0,1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b0,18'h00, 1'b1,1'b1,18'h04, 18'h00101,18'h08, 1'b0,1'b0};
      vecs[5]  = '{1'b0,1'b1,1'b0,18'h00, 1'b1,1'b1,18'h04, 18'h00101,18'h08, 1'b0,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h08, 18'h00102,18'h0C, 1'b0,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h0C, 18'h00103,18'h10, 1'b0,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b1,18'h1E, 1'b0,1'b0,18'h00, 18'h00000,18'h1C, 1'b0,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h1C, 18'h00107,18'h20, 1'b0,1'b0};
      vecs[10] = '{1'b0,1'b1,1'b1,18'h40, 1'b0,1'b0,18'h00, 18'h00000,18'h40, 1'b0,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h40, 18'h00110,18'h44, 1'b0,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b1,18'h6C, 1'b0,1'b0,18'h00, 18'h00000,18'h6C, 1'b0,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h6C, 18'h0011B,18'h70, 1'b0,1'b0};
      vecs[14] = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h70, 18'h0011C,18'h74, 1'b0,1'b0};
      vecs[15] = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h74, 18'h18000,18'h74, 1'b1,1'b0};
      vecs[16] = '{1'b0,1'b0,1'b0,18'h00, 1'b0,1'b0,18'h00, 18'h00000,18'h74, 1'b1,1'b0};
      vecs[17] = '{1'b0,1'b0,1'b1,18'h10, 1'b0,1'b0,18'h00, 18'h00000,18'h74, 1'b1,1'b0};
      vecs[18] = '{1'b1,1'b0,1'b0,18'h00, 1'b0,1'b0,18'h00, 18'h00000,18'h00, 1'b0,1'b0};
      vecs[19] = '{1'b0,1'b0,1'b0,18'h00, 1'b1,1'b1,18'h00, 18'h00100,18'h04, 1'b0,1'b0};

      bus.start = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;

      // Reset state while rst is held.
      #12;
      chk("rst_valid",  32'(bus.valid_out), 32'd0);
      chk("rst_halted", 32'(bus.halted),    32'd0);
      chk("rst_ferr",   32'(bus.fetch_err), 32'd0);
      chk("rst_pc_out", 32'(bus.pc_out),    32'd0);
      chk("rst_instr",  32'(bus.instr_out), 32'd0);
      chk("rst_addr",   32'(bus.imem_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table: drive at negedge, check at the following negedge.
      for (int i = 0; i < 20; i++) begin
         bus.start = vecs[i].start; bus.stall = vecs[i].stall;
         bus.branch_taken = vecs[i].br; bus.branch_target = vecs[i].tgt;
         @(negedge clk);
         $display("vec %0d: valid=%0b pc_out=0x%0h instr=0x%0h addr=0x%0h halted=%0b ferr=%0b",
                  i, bus.valid_out, bus.pc_out, bus.instr_out, bus.imem_addr, bus.halted, bus.fetch_err);
         chk($sformatf("v%0d_valid", i),  32'(bus.valid_out), 32'(vecs[i].valid));
         chk($sformatf("v%0d_addr", i),   32'(bus.imem_addr), 32'(vecs[i].addr));
         chk($sformatf("v%0d_halted", i), 32'(bus.halted),    32'(vecs[i].halted));
         chk($sformatf("v%0d_ferr", i),   32'(bus.fetch_err), 32'(vecs[i].ferr));
         if (vecs[i].chk_data) begin
            chk($sformatf("v%0d_pc_out", i), 32'(bus.pc_out),    32'(vecs[i].pc));
            chk($sformatf("v%0d_instr", i),  32'(bus.instr_out), 32'(vecs[i].instr));
         end
      end
      bus.start = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0;

      // Out-of-range run: no FINISH word anywhere in memory.
      mem[29] = 18'h00100 + 18'd29;
      rst = 1'b1; #1; rst = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cnt = 0; last_pc = '0; last_instr = '0; done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (bus.valid_out) begin
            cnt++; last_pc = bus.pc_out; last_instr = bus.instr_out;
         end
         if (bus.halted) done = 1'b1;
      end
      $display("range run: words=%0d last_pc=0x%0h halted=%0b ferr=%0b", cnt, last_pc, bus.halted, bus.fetch_err);
      chk("oor_halted",     32'(done),          32'd1);
      chk("oor_count",      32'(cnt),           32'd101);
      chk("oor_last_pc",    32'(last_pc),       32'h190);
      chk("oor_last_instr", 32'(last_instr),    32'h164);
      chk("oor_valid",      32'(bus.valid_out), 32'd0);
      chk("oor_ferr",       32'(bus.fetch_err), 32'd1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      $display("restart: halted=%0b ferr=%0b addr=0x%0h", bus.halted, bus.fetch_err, bus.imem_addr);
      chk("restart_ferr",   32'(bus.fetch_err), 32'd0);
      chk("restart_halted", 32'(bus.halted),    32'd0);
      chk("restart_addr",   32'(bus.imem_addr), 32'd0);

      // Asynchronous reset mid-run, between clock edges.
      repeat (3) @(negedge clk);
      chk("pre_rst_valid", 32'(bus.valid_out), 32'd1);
      #2 rst = 1'b1;
      #1;
      $display("async rst: valid=%0b pc_out=0x%0h instr=0x%0h addr=0x%0h", bus.valid_out, bus.pc_out, bus.instr_out, bus.imem_addr);
      chk("arst_valid",  32'(bus.valid_out), 32'd0);
      chk("arst_pc_out", 32'(bus.pc_out),    32'd0);
      chk("arst_instr",  32'(bus.instr_out), 32'd0);
      chk("arst_addr",   32'(bus.imem_addr), 32'd0);
      chk("arst_halted", 32'(bus.halted),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_valid", 32'(bus.valid_out), 32'd0);
      chk("idle_addr",  32'(bus.imem_addr), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 18-bit vector processor. Owns the program counter, drives the word-aligned byte address into `instruction_memory`, and registers the returned 18-bit word into the IF/ID pipeline register for decode. Handles pipeline stall, branch redirect with a one-slot flush, run/halt control on the FINISH word, and detection of out-of-range fetches.

## Interface

Parameters:
- `ADDR_W`, 18: PC / byte-address width.
- `INSTR_W`, 18: instruction width.
- `RESET_PC`, 18'd0: start byte address; must be a multiple of 4.
- `MEM_WORDS`, 101: number of valid instruction words (indices 0..MEM_WORDS-1).
- `FINISH_WORD`, 18'b011000000000000000: encoding that ends the program.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin fetching from `RESET_PC` (sampled in IDLE or HALT).
- `stall`, in, 1: hold PC and IF/ID contents.
- `branch_taken`, in, 1: redirect request from execute.
- `branch_target`, in, ADDR_W: redirect byte address.
- `imem_addr`, out, ADDR_W: byte address to instruction memory; equals the PC register.
- `imem_rd`, in, INSTR_W: combinational read data for `imem_addr`.
- `instr_out`, out, INSTR_W: IF/ID instruction.
- `pc_out`, out, ADDR_W: IF/ID byte address of `instr_out`.
- `valid_out`, out, 1: IF/ID holds a live instruction.
- `halted`, out, 1: FSM is in HALT.
- `fetch_err`, out, 1: sticky flag; last halt was caused by an out-of-range PC.

## Operation

- FSM states: IDLE, RUN, HALT.
- Reset (async, immediate): state=IDLE, PC=`RESET_PC`, `instr_out`=0, `pc_out`=0, `valid_out`=0, `halted`=0, `fetch_err`=0.
- IDLE: PC held, `valid_out`=0. `start`=1 -> RUN with PC=`RESET_PC`.
- RUN, priority per cycle (highest first):
  1. `branch_taken`=1: PC <= `{branch_target[ADDR_W-1:2], 2'b00}` (low bits forced to zero), `valid_out` <= 0 (flush the wrong-path slot). This overrides `stall`.
  2. `stall`=1: PC, `instr_out`, `pc_out` and `valid_out` are all held.
  3. PC word index `PC[ADDR_W-1:2]` >= `MEM_WORDS`: `valid_out` <= 0, `fetch_err` <= 1, state -> HALT.
  4. `imem_rd` == `FINISH_WORD`: `instr_out` <= `imem_rd`, `pc_out` <= PC, `valid_out` <= 1, PC held, state -> HALT.
  5. Otherwise: `instr_out` <= `imem_rd`, `pc_out` <= PC, `valid_out` <= 1, PC <= PC+4.
- PC arithmetic is modulo 2^ADDR_W; PC+4 from 0x3FFFC wraps to 0. With the default `MEM_WORDS` this case is caught first by the range check.
- HALT: `halted`=1 and PC is frozen.
  - On the first HALT cycle not under `stall`, `valid_out` <= 0, so the FINISH word is presented exactly once.
  - `branch_taken` is ignored in HALT.
  - `start`=1 -> RUN with PC=`RESET_PC` and `fetch_err` <= 0.
- `start` is ignored while in RUN.

## Timing

- `imem_addr` is combinational from the PC register; the memory read completes in the same cycle.
- Fetch latency: the word at PC appears on `instr_out` with `valid_out`=1 one cycle after PC is presented.
- Throughput: one instruction per cycle when not stalled.
- `start` sampled at edge N: PC=`RESET_PC` after N; first `valid_out`=1 after edge N+1.
- Branch sampled at edge N:
  - `valid_out`=0 after N.
  - Target instruction appears after N+1.
  - Penalty: one bubble.
- Stall: a cycle with `stall`=1 leaves every output unchanged (stall has no effect in IDLE).
- FINISH fetched at edge N: `halted`=1 and the FINISH word is valid after N; `valid_out`=0 after N+1.
- Reset asserted mid-RUN: outputs go to reset values without waiting for a clock edge; the in-flight instruction is discarded.

## Test plan

- Reset, then `start` for one cycle with memory words 0..3 = A,B,C,D -> `pc_out`/`instr_out` sequence 0/A, 4/B, 8/C, 12/D on consecutive cycles, `valid_out`=1 throughout.
- `branch_taken`=1 with `branch_target`=0x1E (misaligned) while PC=0x10 -> one cycle `valid_out`=0, then `pc_out`=0x1C with word 7.
- `stall` high for 3 cycles at PC=0x08 -> outputs frozen for 3 cycles, then `pc_out`=0x08 followed by 0x0C with no skipped or duplicated word. Repeat with `branch_taken` and `stall` asserted together -> the branch wins.
- FINISH at word 29 -> `pc_out`=0x74 with `instr_out`=0x18000 valid for exactly one cycle, `halted`=1, PC stays at 0x74. A later `start` restarts at 0.
- Memory filled with non-FINISH words -> after word 100 (`pc_out`=0x190), `valid_out`=0, `halted`=1, `fetch_err`=1. `start` clears `fetch_err`.
- `rst` pulsed asynchronously between edges during RUN -> all outputs reset immediately, state IDLE, PC=`RESET_PC`.
